ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 SHALL: start  input  1  request a new operation; sampled only in IDLE or DONE.
REQ-004 SHALL: op  input  2  00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
REQ-005 SHALL: rs_in  input  32  multiplicand or dividend (EX-stage forwarded rs value).
REQ-006 SHALL: rt_in  input  32  multiplier or divisor (EX-stage forwarded rt value).
REQ-007 SHALL: flush  input  1  abort any operation in progress (EX flush).
REQ-008 SHALL: hi_we, lo_we  input  1 each  MTHI/MTLO write enables.
REQ-009 SHALL: wdata  input  32  MTHI/MTLO write data.
REQ-010 SHALL: hi_out, lo_out  output  32 each  architectural HI/LO registers.
REQ-011 SHALL: stall  output  1  combinational pipeline stall request to upstream stages.
REQ-012 SHALL: done  output  1  registered one-cycle pulse marking new HI/LO.
REQ-013 SHALL: div_by_zero  output  1  registered flag, valid only while done=1.

Function
REQ-014 SHALL: FSM states are IDLE, CALC, FIX, DONE.
REQ-015 SHALL: start=1 in IDLE/DONE with flush=0 latches operand magnitudes (abs value for signed ops), result-sign bits, and op, clears 6-bit counter, and enters CALC.
REQ-016 SHALL: exception: DIV/DIVU with rt_in=0 skips CALC/FIX, enters DONE next edge with div_by_zero=1, HI/LO unchanged.
REQ-017 SHALL: CALC performs one radix-2 step per cycle (shift-add multiply, restoring divide), 32 cycles exactly; after the 32nd step, FIX.
REQ-018 SHALL: FIX applies signs (product negated if operand signs differ; quotient negated if signs differ; remainder takes dividend sign), writes HI/LO, enters DONE.
REQ-019 SHALL: multiply result: HI = product[63:32], LO = product[31:0]; divide result: LO = quotient, HI = remainder.
REQ-020 SHALL: DIV 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0x00000000, no flag.
REQ-021 SHALL: latency start edge -> done=1 is 34 edges (1 entry + 32 CALC + 1 FIX); done high exactly one cycle (state DONE).
REQ-022 SHALL: DONE with no start returns to IDLE next edge; DONE with start begins a new operation (back-to-back).
REQ-023 SHALL: stall = (start & state in {IDLE,DONE} & ~flush) | state in {CALC,FIX}.
REQ-024 SHALL: start while in CALC/FIX is ignored.
REQ-025 SHALL: flush=1 in any state forces IDLE next edge, no done, HI/LO unchanged; flush overrides simultaneous start.
REQ-026 SHALL: hi_we/lo_we write wdata only in IDLE or DONE; ignored in CALC/FIX; in DONE they never collide with a result write (result written at FIX edge).
REQ-027 SHALL: start and hi_we/lo_we asserted together: register write occurs and operation starts using rs_in/rt_in as sampled.

Reset
REQ-028 SHALL: reset=1 at a posedge forces IDLE, counter=0, hi_out=0, lo_out=0, done=0, div_by_zero=0, regardless of state or other inputs.
REQ-029 SHALL: reset asserted mid-CALC discards the operation; no done pulse follows.
REQ-030 SHALL: stall=0 while reset=1 is held and state is IDLE with start=0.

Verification
REQ-031 SHALL: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done at edge 34, HI=0xFFFFFFFE, LO=0x00000001, stall high cycles 0-33.
REQ-032 SHALL: MULT 0xFFFFFFFD (-3) x 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-033 SHALL: DIV 0xFFFFFFF9 (-7) / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-034 SHALL: DIVU 0x10 / 0 with HI=0x11, LO=0x22 preloaded via MTHI/MTLO -> done one edge later, div_by_zero=1, HI=0x11, LO=0x22.
REQ-035 SHALL: flush at CALC step 10 -> state IDLE next edge, stall=0, no done, HI/LO unchanged; reset at step 20 -> HI=LO=0, no done.
REQ-036 SHALL: back-to-back MULTU 2x3 then start held in DONE with DIVU 9/4 -> first LO=6, second LO=2, HI=1, two done pulses 34 edges apart.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// EX-stage multiply/divide unit bus: operation request, MTHI/MTLO writes,
// HI/LO results and pipeline stall.
interface ex_muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_in;
  logic [31:0] rt_in;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        stall;
  logic        done;
  logic        div_by_zero;

  modport master (
    output start, op, rs_in, rt_in, flush, hi_we, lo_we, wdata,
    input  hi_out, lo_out, stall, done, div_by_zero
  );

  modport slave (
    input  start, op, rs_in, rt_in, flush, hi_we, lo_we, wdata,
    output hi_out, lo_out, stall, done, div_by_zero
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative MIPS-style HI/LO multiply/divide unit: radix-2 shift-add multiply
// and restoring divide on operand magnitudes, signs applied in a final FIX cycle.
module ex_muldiv (
  input logic         clk,
  input logic         reset,
  ex_muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state, state_nx;
  logic [5:0]  cnt;
  logic [31:0] mag_b;
  logic [63:0] acc;
  logic        div_r;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] hi, lo;
  logic        done_r, dbz_r;

  logic        accept, div0, wr_ok, done_nx;
  logic        rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_nx;
  logic [32:0] div_sh, div_diff;
  logic [63:0] div_nx;
  logic [63:0] prod;
  logic [31:0] quo, rem;

  always_comb begin
    wr_ok   = (state == IDLE) || (state == DONE);
    accept  = bus.start && wr_ok && !bus.flush;
    div0    = bus.op[1] && (bus.rt_in == '0);
    rs_neg  = bus.op[0] && bus.rs_in[31];
    rt_neg  = bus.op[0] && bus.rt_in[31];
    rs_mag  = rs_neg ? -bus.rs_in : bus.rs_in;
    rt_mag  = rt_neg ? -bus.rt_in : bus.rt_in;
    done_nx = ((state == FIX) && !bus.flush) || (accept && div0);

    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nx = div0 ? DONE : CALC;
        else        state_nx = IDLE;
      end
      CALC:    if (cnt == 6'd31) state_nx = FIX;
      FIX:     state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (bus.flush) state_nx = IDLE;
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  // R < divisor keeps the 33-bit trial subtraction free of false borrows.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_b} : '0);
    mul_nx   = {mul_sum, acc[31:1]};
    div_sh   = {acc[63:32], acc[31]};
    div_diff = div_sh - {1'b0, mag_b};
    div_nx   = div_diff[32] ? {div_sh[31:0], acc[30:0], 1'b0}
                            : {div_diff[31:0], acc[30:0], 1'b1};
    prod     = neg_q ? -acc : acc;
    quo      = neg_q ? -acc[31:0] : acc[31:0];
    rem      = neg_r ? -acc[63:32] : acc[63:32];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      mag_b  <= '0;
      acc    <= '0;
      div_r  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
    end else begin
      state  <= state_nx;
      done_r <= done_nx;
      dbz_r  <= accept && div0;

      if (accept) begin
        mag_b <= rt_mag;
        acc   <= {32'h0, rs_mag};
        div_r <= bus.op[1];
        neg_q <= rs_neg ^ rt_neg;
        neg_r <= rs_neg;
        cnt   <= '0;
      end else if ((state == CALC) && !bus.flush) begin
        acc <= div_r ? div_nx : mul_nx;
        cnt <= cnt + 6'd1;
      end

      if ((state == FIX) && !bus.flush) begin
        hi <= div_r ? rem : prod[63:32];
        lo <= div_r ? quo : prod[31:0];
      end else if (wr_ok) begin
        if (bus.hi_we) hi <= bus.wdata;
        if (bus.lo_we) lo <= bus.wdata;
      end
    end
  end

  assign bus.stall       = accept || (state == CALC) || (state == FIX);
  assign bus.hi_out      = hi;
  assign bus.lo_out      = lo;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv: hand-computed HI/LO results,
// latency, stall window, divide-by-zero, flush, reset and back-to-back ops.
module tb_ex_muldiv;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_muldiv_if bus ();

  ex_muldiv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp    = 0;
  int n_bad    = 0;
  int done_cnt = 0;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic hw, input logic [31:0] wd, output int st0);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.rs_in = a; bus.rt_in = b;
    bus.hi_we = hw; bus.wdata = wd;
    #1 st0 = int'(bus.stall);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hi_we = 1'b0;
  endtask

  task automatic wait_done(output int edges, output int sc);
    edges = 0; sc = 0;
    while (bus.done !== 1'b1 && edges < 200) begin
      if (bus.stall === 1'b1) sc++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int stc);
    int st0, e, sc;
    start_op(o, a, b, 1'b0, 32'h0, st0);
    wait_done(e, sc);
    lat = 1 + e;
    stc = st0 + sc;
  endtask

  task automatic mt(input logic hw, input logic lw, input logic [31:0] d);
    @(negedge clk);
    bus.hi_we = hw; bus.lo_we = lw; bus.wdata = d;
    @(posedge clk); #1;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[$] = '{
    '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB},
    '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
    '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
    '{2'b01, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E},
    '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC},
    '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
    '{2'b00, 32'h00012345, 32'h00010000, 32'h00000001, 32'h23450000}
  };

  initial begin
    int lat, stc, st0, e, sc, dc;
    bus.start = 1'b0; bus.op = 2'b00; bus.rs_in = '0; bus.rt_in = '0;
    bus.flush = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", bus.hi_out, 0);
    chk("rst_lo", bus.lo_out, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dbz", bus.div_by_zero, 0);
    chk("rst_stall", bus.stall, 0);
    @(negedge clk) reset = 1'b0;

    // MULTU max x max: latency, stall window, single-cycle done
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, stc);
    chk("multu_lat", lat, 34);
    chk("multu_stall_cycles", stc, 34);
    chk("multu_hi", bus.hi_out, 64'hFFFFFFFE);
    chk("multu_lo", bus.lo_out, 64'h00000001);
    chk("multu_dbz", bus.div_by_zero, 0);
    chk("multu_stall_done", bus.stall, 0);
    idle_cycle();
    chk("multu_done_pulse", bus.done, 0);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, stc);
      chk($sformatf("vec%0d_lat", i), lat, 34);
      chk($sformatf("vec%0d_hi", i), bus.hi_out, vecs[i].hi);
      chk($sformatf("vec%0d_lo", i), bus.lo_out, vecs[i].lo);
      chk($sformatf("vec%0d_dbz", i), bus.div_by_zero, 0);
      idle_cycle();
    end

    // MTHI/MTLO preload then DIVU by zero
    mt(1'b1, 1'b0, 32'h11);
    mt(1'b0, 1'b1, 32'h22);
    chk("mthi", bus.hi_out, 64'h11);
    chk("mtlo", bus.lo_out, 64'h22);
    run_op(2'b10, 32'h10, 32'h0, lat, stc);
    chk("dbz_lat", lat, 1);
    chk("dbz_flag", bus.div_by_zero, 1);
    chk("dbz_hi", bus.hi_out, 64'h11);
    chk("dbz_lo", bus.lo_out, 64'h22);
    idle_cycle();
    chk("dbz_done_pulse", bus.done, 0);

    // start together with MTHI: write lands, operation uses sampled operands
    start_op(2'b00, 32'd4, 32'd5, 1'b1, 32'hABC, st0);
    chk("start_mthi_hi", bus.hi_out, 64'hABC);
    wait_done(e, sc);
    chk("start_mthi_lat", 1 + e, 34);
    chk("start_mthi_res_hi", bus.hi_out, 0);
    chk("start_mthi_res_lo", bus.lo_out, 20);
    idle_cycle();

    // flush mid-CALC with start and MTHI also asserted
    dc = done_cnt;
    start_op(2'b00, 32'd9, 32'd9, 1'b0, 32'h0, st0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1; bus.start = 1'b1; bus.hi_we = 1'b1; bus.wdata = 32'hDEAD;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.start = 1'b0; bus.hi_we = 1'b0;
    chk("flush_stall", bus.stall, 0);
    chk("flush_done", bus.done, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_no_done", done_cnt - dc, 0);
    chk("flush_hi", bus.hi_out, 0);
    chk("flush_lo", bus.lo_out, 20);

    // start during CALC is ignored
    start_op(2'b00, 32'd6, 32'd7, 1'b0, 32'h0, st0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11; bus.rs_in = 32'd100; bus.rt_in = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(e, sc);
    chk("ign_start_lat", e, 27);
    chk("ign_start_lo", bus.lo_out, 42);
    chk("ign_start_hi", bus.hi_out, 0);
    idle_cycle();

    // flush overrides start in IDLE
    dc = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b00; bus.rs_in = 32'd1; bus.rt_in = 32'd1;
    #1 chk("flush_ovr_stall", bus.stall, 0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("flush_ovr_no_done", done_cnt - dc, 0);
    chk("flush_ovr_stall_after", bus.stall, 0);

    // back-to-back: MULTU 2x3 then DIVU 9/4 started from DONE
    dc = done_cnt;
    run_op(2'b00, 32'd2, 32'd3, lat, stc);
    chk("b2b1_lat", lat, 34);
    chk("b2b1_lo", bus.lo_out, 6);
    chk("b2b1_hi", bus.hi_out, 0);
    run_op(2'b10, 32'd9, 32'd4, lat, stc);
    chk("b2b2_lat", lat, 34);
    chk("b2b2_lo", bus.lo_out, 2);
    chk("b2b2_hi", bus.hi_out, 1);
    idle_cycle();
    chk("b2b_done_count", done_cnt - dc, 2);

    // reset at CALC step 20 clears HI/LO and discards the operation
    dc = done_cnt;
    start_op(2'b00, 32'd5, 32'd5, 1'b0, 32'h0, st0);
    repeat (19) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_hi", bus.hi_out, 0);
    chk("rst_mid_lo", bus.lo_out, 0);
    chk("rst_mid_done", bus.done, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("rst_mid_no_done", done_cnt - dc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
